// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins by default; a bounded data streak keeps fetch from starving.
module mem_arbiter #(
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [2:0] STRV      = 3'(STARVE);
  localparam logic [3:0] TMO       = 4'(TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_streak;
  logic [3:0] r_tmo;

  logic w_dreq;
  logic w_ilive;
  logic w_dlive;
  logic w_live;
  logic w_acc;
  logic w_icmp;
  logic w_dcmp;

  always_comb begin
    w_dreq  = dREN | dWEN;
    w_ilive = (r_state == IGNT) & iREN;
    w_dlive = (r_state == DGNT) & w_dreq;
    w_live  = w_ilive | w_dlive;
    w_acc   = (ramstate == RS_ACCESS);
    w_icmp  = w_ilive & w_acc;
    w_dcmp  = w_dlive & w_acc;
    // Completion beats a simultaneous timeout
    memerr  = w_live & ~w_acc &
              ((ramstate == RS_ERROR) | (r_tmo == TMO));
  end

  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE: begin
        if (iREN && (!w_dreq || r_streak >= STRV))
          w_next = IGNT;
        else if (w_dreq)
          w_next = DGNT;
        else
          w_next = IDLE;
      end
      IGNT, DGNT: begin
        if (w_live && !w_acc && !memerr)
          w_next = r_state;
        else
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (1'b1)
      (r_state == IGNT): begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      (r_state == DGNT): begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
    iwait = ~w_icmp;
    dwait = ~w_dcmp;
    iload = ramload;
    dload = ramload;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_tmo    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE)
        r_tmo <= '0;
      else if (!w_acc)
        r_tmo <= r_tmo + 4'd1;
      if (!iREN || w_icmp)
        r_streak <= '0;
      else if (w_dcmp && r_streak < STRV)
        r_streak <= r_streak + 3'd1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE, default 4, maximum consecutive data grants while an instruction request waits.
REQ-002 Parameter: TIMEOUT, default 15, maximum cycles in a grant state without ramstate ACCESS.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 iREN  in  1  instruction read request; iaddr  in  32  instruction word address.
REQ-006 iwait  out  1  instruction stall; iload  out  32  instruction read data.
REQ-007 dREN/dWEN  in  1 each  data read/write request; daddr  in  32; dstore  in  32  write data.
REQ-008 dwait  out  1  data stall; dload  out  32  data read data.
REQ-009 ramREN/ramWEN  out  1 each; ramaddr  out  32; ramstore  out  32  single RAM port.
REQ-010 ramload  in  32; ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-011 memerr  out  1  one-cycle pulse on RAM error or timeout.

Function
REQ-012 FSM states are IDLE, IGNT and DGNT; state is registered.
REQ-013 IDLE, data request pending (dREN|dWEN), streak<STARVE or iREN=0: next state DGNT.
REQ-014 IDLE, iREN=1 and (no data request or streak==STARVE): next state IGNT.
REQ-015 IDLE with no requests: remains IDLE; all ram outputs 0.
REQ-016 IGNT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-017 DGNT: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both are high), ramaddr=daddr, ramstore=dstore.
REQ-018 Completion is a cycle in IGNT/DGNT with ramstate==ACCESS: the matching wait is 0 that cycle only, and the next state is IDLE.
REQ-019 iload=ramload and dload=ramload, combinationally; they are valid only in the completion cycle.
REQ-020 iwait=1 and dwait=1 in every cycle except their own completion cycle.
REQ-021 Minimum latency: request seen in IDLE at edge N, grant at N+1, earliest completion is the cycle after N+1, so 2 cycles from request to data.
REQ-022 Abort: the granted requester drops its request while in grant. Next state is IDLE, no completion, no memerr, and ram enables deassert combinationally that cycle.
REQ-023 The streak counter (3 bits) increments on each data completion while iREN=1.
REQ-024 The streak counter clears on instruction completion or any cycle with iREN=0, and saturates at STARVE.
REQ-025 The timeout counter (4 bits) clears on entry to a grant state and increments each grant cycle while ramstate!=ACCESS.
REQ-026 When the timeout counter reaches TIMEOUT: memerr=1 for one cycle, next state IDLE, wait stays 1.
REQ-027 ramstate==ERROR in a grant state: memerr=1 that cycle, next state IDLE, wait stays 1, streak unchanged.
REQ-028 Back-to-back: a requester still asserting after completion is re-arbitrated from IDLE, with no bypass of IDLE.

Reset
REQ-029 On nRST=0: state=IDLE, streak=0, timeout=0, memerr=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
REQ-030 Reset mid-grant abandons the transaction immediately (asynchronously), with no completion or memerr after release.
REQ-031 The first arbitration after reset release occurs on the first rising edge with nRST=1.

Verification
REQ-032 iREN=1, iaddr=0x40, RAM answers ACCESS on the second grant cycle with ramload=0xDEADBEEF -> iwait=0 for exactly one cycle, iload=0xDEADBEEF, ramaddr=0x40 during grant.
REQ-033 dREN and iREN both asserted from reset, each RAM access takes 1 cycle -> grants in order D,D,D,D,I,D,D,D,D,I; iwait never falls before the 4th data completion.
REQ-034 dWEN=dREN=1, daddr=0x100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678, dwait=0 on ACCESS.
REQ-035 ramstate held BUSY in DGNT -> memerr pulses once 15 cycles after the grant, state returns IDLE, dwait=1 throughout.
REQ-036 dREN dropped on the 2nd grant cycle -> ramREN=0 that cycle, IDLE next, no memerr, dwait=1.
REQ-037 nRST pulsed low during IGNT with ramstate BUSY -> all outputs at reset values asynchronously, IDLE after release, no stale completion.
